// File: rtl/jtag_dap_seq_if.sv
// Request/response bus from the DAP command controller, and the command bus to jtagIF.
interface jtag_dap_seq_if;
   logic        req;
   logic [1:0]  req_op;
   logic        req_apndp;
   logic        req_rnw;
   logic [1:0]  req_addr;
   logic [31:0] req_wdata;
   logic        ready;
   logic        done;
   logic [2:0]  rsp_ack;
   logic [31:0] rsp_rdata;

   modport master (
      output req, req_op, req_apndp, req_rnw, req_addr, req_wdata,
      input  ready, done, rsp_ack, rsp_rdata
   );
   modport slave (
      input  req, req_op, req_apndp, req_rnw, req_addr, req_wdata,
      output ready, done, rsp_ack, rsp_rdata
   );
endinterface

interface jtag_dap_jtag_if;
   logic [1:0]  j_cmd;
   logic [3:0]  j_ir;
   logic        j_apndp;
   logic        j_rnw;
   logic [1:0]  j_addr32;
   logic [31:0] j_dwrite;
   logic        j_go;
   logic        j_idle;
   logic [2:0]  j_ack;
   logic [31:0] j_dread;

   modport master (
      output j_cmd, j_ir, j_apndp, j_rnw, j_addr32, j_dwrite, j_go,
      input  j_idle, j_ack, j_dread
   );
   modport slave (
      input  j_cmd, j_ir, j_apndp, j_rnw, j_addr32, j_dwrite, j_go,
      output j_idle, j_ack, j_dread
   );
endinterface

// File: rtl/jtag_dap_seq.sv
// DP/AP transfer sequencer: IR caching, WAIT retries and RDBUFF flush onto jtagIF, one ack/data per request.
// Latency is set by jtagIF; ready is low from acceptance until the cycle after done, j_go held until jtagIF leaves idle.
module jtag_dap_seq #(
   parameter int unsigned RETRIES  = 8,
   parameter logic [3:0]  IR_APACC = 4'hB,
   parameter logic [3:0]  IR_DPACC = 4'hA
) (
   input logic             clk,
   input logic             rst,
   jtag_dap_seq_if.slave   rq,
   jtag_dap_jtag_if.master jt
);

   localparam int RW = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(RETRIES);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ISSUE    = 3'd1;
   localparam logic [2:0] S_WAITDONE = 3'd2;
   localparam logic [2:0] S_DECIDE   = 3'd3;
   localparam logic [2:0] S_DONE     = 3'd4;

   localparam logic [1:0] CMD_IR     = 2'd0;
   localparam logic [1:0] CMD_TFR    = 2'd1;
   localparam logic [1:0] CMD_READID = 2'd2;
   localparam logic [1:0] CMD_RESET  = 2'd3;

   localparam logic [1:0] OP_TFR    = 2'd0;
   localparam logic [1:0] OP_LRESET = 2'd1;
   localparam logic [1:0] OP_READID = 2'd2;

   localparam logic [2:0] ACK_WAIT = 3'b001;
   localparam logic [2:0] ACK_OK   = 3'b010;

   logic [2:0]    state;
   logic          cache_vld;
   logic [3:0]    cache_ir;
   logic [RW-1:0] retry_cnt;
   logic          flush;

   logic          done_r;
   logic [2:0]    ack_r;
   logic [31:0]   rdata_r;

   logic [1:0]    cmd_r;
   logic [3:0]    ir_r;
   logic          apndp_r;
   logic          rnw_r;
   logic [1:0]    addr_r;
   logic [31:0]   dwrite_r;
   logic          go_r;

   logic [3:0]    tgt_ir;
   logic          tgt_hit;
   logic          dp_hit;

   assign tgt_ir  = rq.req_apndp ? IR_APACC : IR_DPACC;
   assign tgt_hit = cache_vld && (cache_ir == tgt_ir);
   assign dp_hit  = cache_vld && (cache_ir == IR_DPACC);

   assign rq.ready     = (state == S_IDLE);
   assign rq.done      = done_r;
   assign rq.rsp_ack   = ack_r;
   assign rq.rsp_rdata = rdata_r;

   assign jt.j_cmd    = cmd_r;
   assign jt.j_ir     = ir_r;
   assign jt.j_apndp  = apndp_r;
   assign jt.j_rnw    = rnw_r;
   assign jt.j_addr32 = addr_r;
   assign jt.j_dwrite = dwrite_r;
   assign jt.j_go     = go_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cache_vld <= 1'b0;
         cache_ir  <= 4'h0;
         retry_cnt <= '0;
         flush     <= 1'b0;
         done_r    <= 1'b0;
         ack_r     <= 3'b000;
         rdata_r   <= 32'h0;
         cmd_r     <= CMD_IR;
         ir_r      <= IR_DPACC;
         apndp_r   <= 1'b0;
         rnw_r     <= 1'b1;
         addr_r    <= 2'b00;
         dwrite_r  <= 32'h0;
         go_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rq.req) begin
                  // The j_* field registers double as the latched request.
                  retry_cnt <= '0;
                  flush     <= 1'b0;
                  apndp_r   <= rq.req_apndp;
                  rnw_r     <= rq.req_rnw;
                  addr_r    <= rq.req_addr;
                  dwrite_r  <= rq.req_wdata;
                  ir_r      <= tgt_ir;
                  case (rq.req_op)
                     OP_TFR: begin
                        cmd_r <= tgt_hit ? CMD_TFR : CMD_IR;
                        go_r  <= 1'b1;
                        state <= S_ISSUE;
                     end
                     OP_LRESET: begin
                        cmd_r <= CMD_RESET;
                        go_r  <= 1'b1;
                        state <= S_ISSUE;
                     end
                     OP_READID: begin
                        cmd_r <= CMD_READID;
                        go_r  <= 1'b1;
                        state <= S_ISSUE;
                     end
                     default: begin
                        done_r  <= 1'b1;
                        ack_r   <= 3'b000;
                        rdata_r <= 32'h0;
                        state   <= S_DONE;
                     end
                  endcase
               end
            end
            S_ISSUE: begin
               if (!jt.j_idle) begin
                  go_r  <= 1'b0;
                  state <= S_WAITDONE;
               end
            end
            S_WAITDONE: begin
               if (jt.j_idle) state <= S_DECIDE;
            end
            S_DECIDE: begin
               case (cmd_r)
                  CMD_IR: begin
                     cache_vld <= 1'b1;
                     cache_ir  <= ir_r;
                     cmd_r     <= CMD_TFR;
                     go_r      <= 1'b1;
                     state     <= S_ISSUE;
                  end
                  CMD_RESET, CMD_READID: begin
                     // TLR after either command leaves IDCODE in IR.
                     cache_vld <= 1'b0;
                     done_r    <= 1'b1;
                     ack_r     <= ACK_OK;
                     rdata_r   <= (cmd_r == CMD_READID) ? jt.j_dread : 32'h0;
                     state     <= S_DONE;
                  end
                  default: begin
                     if (jt.j_ack == ACK_WAIT && retry_cnt < RETRY_MAX) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        go_r      <= 1'b1;
                        state     <= S_ISSUE;
                     end else if (jt.j_ack != ACK_OK || flush || !rnw_r) begin
                        done_r  <= 1'b1;
                        ack_r   <= jt.j_ack;
                        rdata_r <= flush ? jt.j_dread : 32'h0;
                        state   <= S_DONE;
                     end else begin
                        // Posted read: fetch the result through DP RDBUFF.
                        flush     <= 1'b1;
                        retry_cnt <= '0;
                        apndp_r   <= 1'b0;
                        rnw_r     <= 1'b1;
                        addr_r    <= 2'b11;
                        ir_r      <= IR_DPACC;
                        cmd_r     <= dp_hit ? CMD_TFR : CMD_IR;
                        go_r      <= 1'b1;
                        state     <= S_ISSUE;
                     end
                  end
               endcase
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jtag_dap_seq.sv
// Bench for jtag_dap_seq: a jtagIF responder with scripted acks, and a request-level reference model.
module tb_jtag_dap_seq;
   localparam int unsigned RETRIES = 8;
   localparam logic [3:0] IR_AP = 4'hB;
   localparam logic [3:0] IR_DP = 4'hA;
   localparam logic [1:0] C_IR  = 2'd0;
   localparam logic [1:0] C_TFR = 2'd1;
   localparam logic [1:0] C_ID  = 2'd2;
   localparam logic [1:0] C_RST = 2'd3;

   typedef struct packed {
      logic [1:0]  cmd;
      logic [3:0]  ir;
      logic        apndp;
      logic        rnw;
      logic [1:0]  addr;
      logic [31:0] dw;
   } step_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jtag_dap_seq_if  rq ();
   jtag_dap_jtag_if jt ();

   jtag_dap_seq #(.RETRIES(RETRIES), .IR_APACC(IR_AP), .IR_DPACC(IR_DP)) dut (
      .clk (clk),
      .rst (rst),
      .rq  (rq),
      .jt  (jt)
   );

   int checks = 0;
   int failures = 0;
   int done_cnt = 0;
   int stab_err = 0;
   int go_err = 0;
   int div = 1;
   bit chk_stab = 1'b1;
   logic [31:0] rd_word = 32'h0;
   logic [31:0] idcode = 32'h0;
   logic [2:0] ack_q[$];
   logic [2:0] m_acks[$];
   step_t hs_q[$];
   step_t exp_q[$];
   bit m_vld = 1'b0;
   logic [3:0] m_ir = 4'h0;
   int r_div_cnt = 0;
   int r_busy = 0;
   step_t r_cur;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic step_t cur_fields();
      return {jt.j_cmd, jt.j_ir, jt.j_apndp, jt.j_rnw, jt.j_addr32, jt.j_dwrite};
   endfunction

   function automatic step_t mk(input logic [1:0] c, input logic [3:0] ir, input logic ap, input logic rn,
                                input logic [1:0] ad, input logic [31:0] dw);
      return {c, ir, ap, rn, ad, dw};
   endfunction

   // Only the fields that matter for each command are compared.
   function automatic logic [41:0] norm(input step_t s);
      step_t n;
      n = '0;
      n.cmd = s.cmd;
      if (s.cmd == C_IR) n.ir = s.ir;
      else if (s.cmd == C_TFR) begin
         n.apndp = s.apndp;
         n.rnw   = s.rnw;
         n.addr  = s.addr;
         if (!s.rnw) n.dw = s.dw;
      end
      return n;
   endfunction

   // jtagIF responder: takes go on a divider tick, stays busy 3..6 cycles, then returns ack/data.
   initial begin
      jt.j_idle  = 1'b1;
      jt.j_ack   = 3'b000;
      jt.j_dread = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (r_busy > 0) begin
            if (jt.j_go) go_err++;
            if (chk_stab && cur_fields() !== r_cur) stab_err++;
            r_busy--;
            if (r_busy == 0) begin
               jt.j_idle = 1'b1;
               if (r_cur.cmd == C_TFR) begin
                  jt.j_ack   = (ack_q.size() > 0) ? ack_q.pop_front() : 3'b010;
                  jt.j_dread = rd_word;
               end else begin
                  jt.j_ack   = 3'b010;
                  jt.j_dread = (r_cur.cmd == C_ID) ? idcode : 32'h0;
               end
            end
         end else if (jt.j_go && r_div_cnt == 0) begin
            r_cur = cur_fields();
            hs_q.push_back(r_cur);
            jt.j_idle = 1'b0;
            r_busy = $urandom_range(6, 3);
         end
         r_div_cnt = (r_div_cnt + 1) % div;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rq.done === 1'b1) done_cnt++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

   task automatic push_ir(input logic [3:0] want);
      if (!(m_vld && m_ir == want)) begin
         exp_q.push_back(mk(C_IR, want, 1'b0, 1'b0, 2'b00, 32'h0));
         m_vld = 1'b1;
         m_ir  = want;
      end
   endtask

   task automatic run_tfr(input logic ap, input logic rn, input logic [1:0] ad, input logic [31:0] dw,
                          output logic [2:0] a);
      int tries = 0;
      forever begin
         exp_q.push_back(mk(C_TFR, 4'h0, ap, rn, ad, dw));
         a = (m_acks.size() > 0) ? m_acks.pop_front() : 3'b010;
         if (a == 3'b001 && tries < int'(RETRIES)) tries++;
         else break;
      end
   endtask

   task automatic predict(input logic [1:0] op, input logic ap, input logic rn, input logic [1:0] ad,
                          input logic [31:0] wd, output logic [2:0] eack, output logic [31:0] erd,
                          output bit rdv);
      logic [2:0] a;
      exp_q.delete();
      eack = 3'b000;
      erd  = 32'h0;
      rdv  = 1'b0;
      case (op)
         2'd0: begin
            push_ir(ap ? IR_AP : IR_DP);
            run_tfr(ap, rn, ad, wd, a);
            if (a == 3'b010 && rn) begin
               push_ir(IR_DP);
               run_tfr(1'b0, 1'b1, 2'b11, wd, a);
               erd = rd_word;
               rdv = 1'b1;
            end
            eack = a;
         end
         2'd1: begin
            exp_q.push_back(mk(C_RST, 4'h0, 1'b0, 1'b0, 2'b00, 32'h0));
            m_vld = 1'b0;
            eack  = 3'b010;
         end
         2'd2: begin
            exp_q.push_back(mk(C_ID, 4'h0, 1'b0, 1'b0, 2'b00, 32'h0));
            m_vld = 1'b0;
            eack  = 3'b010;
            erd   = idcode;
            rdv   = 1'b1;
         end
         default: eack = 3'b000;
      endcase
   endtask

   task automatic do_req(input string tag, input logic [1:0] op, input logic ap, input logic rn,
                         input logic [1:0] ad, input logic [31:0] wd, input int hold);
      logic [2:0] eack;
      logic [31:0] erd;
      bit rdv;
      int d0;
      bit got = 1'b0;
      m_acks = ack_q;
      predict(op, ap, rn, ad, wd, eack, erd, rdv);
      hs_q.delete();
      check({tag, "/ready_idle"}, rq.ready, 1);
      rq.req = 1'b1; rq.req_op = op; rq.req_apndp = ap; rq.req_rnw = rn;
      rq.req_addr = ad; rq.req_wdata = wd;
      d0 = done_cnt;
      for (int c = 1; c <= 4000; c++) begin
         @(negedge clk);
         if (c == 1) check({tag, "/ready_drop"}, rq.ready, 0);
         if (c >= hold) rq.req = 1'b0;
         if (rq.done === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      rq.req = 1'b0;
      check({tag, "/done_seen"}, got, 1);
      if (got) begin
         check({tag, "/ack"}, rq.rsp_ack, eack);
         if (rdv) check({tag, "/rdata"}, rq.rsp_rdata, erd);
         check({tag, "/steps"}, hs_q.size(), exp_q.size());
         for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
            check($sformatf("%s/step%0d", tag, i), norm(hs_q[i]), norm(exp_q[i]));
         @(negedge clk);
         check({tag, "/ready_back"}, rq.ready, 1);
         check({tag, "/done_once"}, done_cnt - d0, 1);
      end
      ack_q.delete();
   endtask

   initial begin
      int d0;
      bit got;
      int n;
      int r;
      logic [1:0] op;
      rq.req = 1'b0; rq.req_op = 2'b00; rq.req_apndp = 1'b0; rq.req_rnw = 1'b0;
      rq.req_addr = 2'b00; rq.req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      check("rst/ready", rq.ready, 1);
      check("rst/done", rq.done, 0);
      check("rst/rsp_ack", rq.rsp_ack, 0);
      check("rst/rsp_rdata", rq.rsp_rdata, 0);
      check("rst/j_go", jt.j_go, 0);
      check("rst/j_cmd", jt.j_cmd, 0);
      check("rst/j_ir", jt.j_ir, 4'hA);
      check("rst/j_apndp", jt.j_apndp, 0);
      check("rst/j_rnw", jt.j_rnw, 1);
      check("rst/j_addr32", jt.j_addr32, 0);
      check("rst/j_dwrite", jt.j_dwrite, 0);
      rst = 1'b0;
      @(negedge clk);

      div = 2;
      do_req("dp_wr_cold", 2'd0, 1'b0, 1'b0, 2'b01, 32'h5000_0000, 1);
      check("dp_wr_cold/handshakes", hs_q.size(), 2);

      rd_word = 32'hDEAD_BEEF;
      do_req("ap_rd", 2'd0, 1'b1, 1'b1, 2'b11, 32'h1234_5678, 2);
      check("ap_rd/handshakes", hs_q.size(), 4);
      check("ap_rd/rdata_const", rq.rsp_rdata, 32'hDEAD_BEEF);
      do_req("ap_wr", 2'd0, 1'b1, 1'b0, 2'b00, 32'hA5A5_0001, 1);
      check("ap_wr/handshakes", hs_q.size(), 2);

      div = 3;
      ack_q = '{3'b001, 3'b001, 3'b001};
      do_req("wait3", 2'd0, 1'b0, 1'b0, 2'b10, 32'h0000_00F0, 1);
      check("wait3/handshakes", hs_q.size(), 5);
      check("wait3/ack_const", rq.rsp_ack, 3'b010);
      for (int i = 0; i < 12; i++) ack_q.push_back(3'b001);
      do_req("wait_forever", 2'd0, 1'b0, 1'b0, 2'b10, 32'h0000_00F1, 1);
      check("wait_forever/handshakes", hs_q.size(), 9);
      check("wait_forever/ack_const", rq.rsp_ack, 3'b001);

      ack_q = '{3'b100};
      do_req("ap_rd_fault", 2'd0, 1'b1, 1'b1, 2'b01, 32'h0, 1);
      check("ap_rd_fault/handshakes", hs_q.size(), 2);
      check("ap_rd_fault/ack_const", rq.rsp_ack, 3'b100);

      idcode = 32'h4BA0_0477;
      do_req("readid", 2'd2, 1'b0, 1'b0, 2'b00, 32'h0, 1);
      check("readid/handshakes", hs_q.size(), 1);
      check("readid/rdata_const", rq.rsp_rdata, 32'h4BA0_0477);
      do_req("after_id", 2'd0, 1'b0, 1'b0, 2'b00, 32'h0000_0022, 1);
      check("after_id/handshakes", hs_q.size(), 2);

      do_req("reserved", 2'd3, 1'b1, 1'b1, 2'b11, 32'h0, 2);
      check("reserved/handshakes", hs_q.size(), 0);

      // Reset while a TFR is in flight.
      ack_q.delete();
      hs_q.delete();
      d0 = done_cnt;
      rq.req = 1'b1; rq.req_op = 2'd0; rq.req_apndp = 1'b0; rq.req_rnw = 1'b0;
      rq.req_addr = 2'b01; rq.req_wdata = 32'h0BAD_0BAD;
      @(negedge clk);
      rq.req = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         if (hs_q.size() >= 1 && jt.j_idle === 1'b0 && jt.j_go === 1'b0) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_mid/waitdone_reached", got, 1);
      chk_stab = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid/ready", rq.ready, 1);
      check("rst_mid/j_go", jt.j_go, 0);
      check("rst_mid/done", rq.done, 0);
      rst = 1'b0;
      m_vld = 1'b0;
      for (int c = 0; c < 200 && jt.j_idle !== 1'b1; c++) @(negedge clk);
      @(negedge clk);
      chk_stab = 1'b1;
      ack_q.delete();
      repeat (3) @(negedge clk);
      check("rst_mid/no_done", done_cnt - d0, 0);
      do_req("rst_after", 2'd0, 1'b0, 1'b0, 2'b01, 32'h0000_0033, 1);
      check("rst_after/ir_first", (hs_q.size() > 0) ? {62'b0, hs_q[0].cmd} : 64'hFFFF, C_IR);

      for (int t = 0; t < 40; t++) begin
         r = $urandom_range(9, 0);
         op = (r < 6) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
         div = $urandom_range(4, 1);
         rd_word = $urandom;
         idcode = $urandom;
         n = $urandom_range(12, 0);
         for (int i = 0; i < n; i++)
            ack_q.push_back(($urandom_range(9, 0) < 7) ? 3'b001 :
                            ($urandom_range(1, 0) != 0) ? 3'b010 : 3'b100);
         do_req($sformatf("rnd%0d", t), op, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                2'($urandom_range(3, 0)), $urandom, $urandom_range(2, 1));
      end

      check("field_stability_errors", stab_err, 0);
      check("go_during_busy_errors", go_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_dap_seq.md
# jtag_dap_seq

Transfer sequencer sitting between the DAP command controller and `jtagIF`. Accepts one DP/AP register request at a time and turns it into the `jtagIF` command sequence it needs: IR select with IR caching, the DR transfer, WAIT retries, and the JTAG-DP posted-read flush through RDBUFF. It also forwards line reset and ID-read requests. It owns `jtagIF`'s `cmd`/`ir`/`go` and request fields, and returns a single ack/data result per request.

## Interface

Parameters:
- `RETRIES`, 8: maximum re-issues of a transfer after a WAIT ack (0 = no retry).
- `IR_APACC`, 4'hB: IR value for AP access.
- `IR_DPACC`, 4'hA: IR value for DP access.

Ports (clock and reset first):
- `clk` input 1: system clock. The only clock.
- `rst` input 1: synchronous, active-high reset.
- `req` input 1: request strobe, sampled only while `ready`=1.
- `req_op` input 2: 0 = register transfer, 1 = line reset, 2 = read ID, 3 = reserved (completes immediately, ack 3'b000).
- `req_apndp` input 1: AP(1) or DP(0).
- `req_rnw` input 1: read(1) or write(0).
- `req_addr` input 2: register address bits [3:2].
- `req_wdata` input 32: write data.
- `ready` output 1: able to accept a request.
- `done` output 1: one-cycle pulse when a request completes.
- `rsp_ack` output 3: final ack, held until the next `done`.
- `rsp_rdata` output 32: read or ID data, held until the next `done`.
- `j_cmd` output 2: to `jtagIF` `cmd` (0 = IR, 1 = TFR, 2 = READID, 3 = RESET).
- `j_ir` output 4: to `jtagIF` `ir`.
- `j_apndp`, `j_rnw` outputs 1; `j_addr32` output 2; `j_dwrite` output 32: to the `jtagIF` request fields.
- `j_go` output 1: to `jtagIF` `go`.
- `j_idle` input 1: from `jtagIF` `idle`.
- `j_ack` input 3: from `jtagIF` `ack`.
- `j_dread` input 32: from `jtagIF` `dread`.

## Operation

- States: IDLE, ISSUE, WAITDONE, DECIDE, DONE.
- The request is latched on `req & ready` and stays in internal registers for the whole sequence. Outputs in IDLE: `ready`=1.
- Each `jtagIF` step is handled the same way:
  - ISSUE: drive `j_cmd`/`j_ir`/`j_*` and hold `j_go`=1 until `j_idle`=0.
  - WAITDONE: `j_go`=0; wait until `j_idle`=1.
  - DECIDE: choose the next step using `j_ack`/`j_dread`.
- IR cache: 5-bit register holding a valid flag plus the IR value.
  - Cleared on `rst` and after any line reset.
  - An IR step is issued only if the cache is invalid or differs from the required IR. The cache is updated when that IR step completes.
- Register transfer sequence:
  - (a) IR select if needed.
  - (b) TFR with the latched apndp/rnw/addr/wdata.
  - (c) If `j_ack`=3'b001 (WAIT) and retries used < `RETRIES`: increment the retry count and reissue (b) without an IR step. If retries are exhausted, finish with ack 3'b001.
  - (d) If ack ≠ 3'b010: finish with that ack and no flush.
  - (e) If write: finish with ack 3'b010.
  - (f) If read: IR select DPACC if needed, then TFR with rnw=1, apndp=0, addr32=2'b11 (RDBUFF). That flush TFR gets its own WAIT retries, with the counter reset to 0. `rsp_rdata` = `j_dread` of the flush. `rsp_ack` = flush ack.
- Line reset: single RESET step; ack reported 3'b010; IR cache invalidated.
- Read ID: single READID step; `rsp_rdata` = `j_dread`; ack 3'b010; IR cache invalidated, because TLR forces IDCODE.
- Retry counter width is $clog2(`RETRIES`+1), minimum 1. It saturates and never wraps.

## Timing

- Reset values: `ready`=1, `done`=0, `rsp_ack`=3'b000, `rsp_rdata`=0, `j_go`=0, `j_cmd`=0, `j_ir`=`IR_DPACC`, `j_apndp`=0, `j_rnw`=1, `j_addr32`=0, `j_dwrite`=0.
- `ready` drops the cycle after acceptance and returns in the cycle after the `done` pulse.
- `req` while `ready`=0 is ignored.
- `j_*` fields are stable from the ISSUE entry cycle until `j_idle` returns to 1. `j_go` is never high in the same cycle as WAITDONE.
- ISSUE lasts until `jtagIF` sees `go & rising`, so duration is unbounded and set by the divider. ISSUE entry requires `j_idle`=1.
- DECIDE samples `j_ack`/`j_dread` in the cycle after `j_idle` rises. It takes 1 cycle per step.
- `done`, `rsp_ack` and `rsp_rdata` update in the same cycle.
- `rst` mid-sequence returns to IDLE next cycle with reset values. The in-flight request is dropped and no `done` is issued.

## Test plan

- DP write, addr 2'b01, data 32'h5000_0000, cache cold → IR(4'hA), then TFR (rnw=0); `done` with `rsp_ack`=3'b010; exactly 2 `go` handshakes.
- AP read, addr 2'b11, DP IR cached → IR(4'hB), TFR, IR(4'hA), TFR RDBUFF; model returns 32'hDEAD_BEEF on flush → `rsp_rdata`=32'hDEAD_BEEF; 4 handshakes. A second AP write immediately after issues IR(4'hB) + TFR only.
- Model returns WAIT 3 times, then OK, on a DP write with `RETRIES`=8 → 1 IR + 4 TFRs, ack 3'b010. With WAIT forever → 9 TFRs, ack 3'b001.
- Model returns ack 3'b100 on an AP read → no RDBUFF flush; `rsp_ack`=3'b100.
- Read ID, model ID 32'h4BA0_0477 → single READID step, `rsp_rdata`=32'h4BA0_0477; next DP transfer re-issues IR.
- `rst` asserted while in WAITDONE of a TFR → next cycle `ready`=1, `j_go`=0, no `done`; following request re-sends IR.
